// File: rtl/mem_stage_unit_pkg.sv
// mem_stage_unit_pkg: shared field positions and FSM encoding for the MEM stage
package mem_stage_unit_pkg;
  localparam int RW_BIT  = 1;
  localparam int M2R_BIT = 0;
  localparam int BR_BIT  = 2;
  localparam int MR_BIT  = 1;
  localparam int MW_BIT  = 0;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/mem_stage_unit_if.sv
// mem_stage_unit_if: EX/MEM fields in, branch resolution, stall and MEM/WB register out
// master drives the EX/MEM side and observes results; slave is the MEM stage.
interface mem_stage_unit_if;
  logic [31:0] Adder;
  logic [31:0] ALU;
  logic [31:0] RD2;
  logic [4:0]  Mux5bit;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic        ZF;
  logic        PCSrc;
  logic [31:0] BranchAddr;
  logic        stall;
  logic [1:0]  wbWB;
  logic [31:0] wbReadData;
  logic [31:0] wbALU;
  logic [4:0]  wbMux5bit;
  modport master (
    output Adder, ALU, RD2, Mux5bit, WB, M, ZF,
    input  PCSrc, BranchAddr, stall, wbWB, wbReadData, wbALU, wbMux5bit
  );
  modport slave (
    input  Adder, ALU, RD2, Mux5bit, WB, M, ZF,
    output PCSrc, BranchAddr, stall, wbWB, wbReadData, wbALU, wbMux5bit
  );
endinterface

// File: rtl/mem_stage_unit_data_mem_array.sv
// data_mem_array: word RAM with synchronous write and a registered, enabled read port
// Ports: clk, rst_n (clears only the read register), we/re strobes, addr word index,
// wdata store word, rdata last word read (holds between reads).
module data_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= 32'd0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM stage - branch resolve, multi-cycle data access with stall, MEM/WB register
// Ports: clk, rst_n (async, active low), bus (mem_stage_unit_if.slave: EX/MEM fields in,
// PCSrc/BranchAddr/stall and MEM/WB fields out). With MISALIGN_TRAP_EN defined,
// misaligned accesses skip the array and a sticky misalign output is added.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8,
  parameter int MEM_LAT     = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_stage_unit_if.slave bus
`ifdef MISALIGN_TRAP_EN
  , output logic misalign
`endif
);
  localparam bit         MULTI  = MEM_LAT > 1;
  localparam logic [3:0] LAT_M2 = MULTI ? 4'(MEM_LAT - 2) : 4'd0;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_W-1:0] idx;
  logic wr, rd, mis, req, done, stall_i;
  logic [1:0] wb_q;
  logic [31:0] alu_q, rdata;
  logic [4:0] rd_q;
  assign idx = bus.ALU[ADDR_W+1:2];
  assign wr  = bus.M[MW_BIT];
  assign rd  = bus.M[MR_BIT] & ~bus.M[MW_BIT];
`ifdef MISALIGN_TRAP_EN
  assign mis = (bus.M[MR_BIT] | bus.M[MW_BIT]) & (|bus.ALU[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign req = (bus.M[MR_BIT] | bus.M[MW_BIT]) & ~mis;
  assign done    = rst_n && ((state == IDLE) ? (req && !MULTI) : (cnt == 4'd0));
  // stall is gated by reset so a held request cannot freeze the pipe while in reset
  assign stall_i = rst_n && ((state == IDLE) ? (req && MULTI) : (cnt != 4'd0));
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE && req && MULTI) begin
      state_n = BUSY;
      cnt_n   = LAT_M2;
    end else if (state == BUSY) begin
      state_n = (cnt == 4'd0) ? IDLE : BUSY;
      cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      wb_q  <= 2'b00;
      alu_q <= 32'd0;
      rd_q  <= 5'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wb_q  <= (stall_i || mis) ? 2'b00 : bus.WB;
      if (!stall_i) begin
        alu_q <= bus.ALU;
        rd_q  <= bus.Mux5bit;
      end
    end
`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign <= 1'b0;
    else if (mis) misalign <= 1'b1;
`endif
  // the RAM read register doubles as the MEM/WB load-data field
  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(done & wr),
    .re(done & rd),
    .addr(idx),
    .wdata(bus.RD2),
    .rdata(rdata)
  );
  assign bus.PCSrc      = bus.M[BR_BIT] & bus.ZF;
  assign bus.BranchAddr = bus.Adder;
  assign bus.stall      = stall_i;
  assign bus.wbWB       = wb_q;
  assign bus.wbALU      = alu_q;
  assign bus.wbMux5bit  = rd_q;
  assign bus.wbReadData = rdata;
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed checks of mem_stage_unit at MEM_LAT 1, 2 and 4
module tb_mem_stage_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] d;
  logic st;
  logic [1:0] w;
  logic [31:0] a;
  logic [4:0] r;
  always #5 clk = ~clk;
  mem_stage_unit_if b1 ();
  mem_stage_unit_if b2 ();
  mem_stage_unit_if b4 ();
  mem_stage_unit #(.MEM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_stage_unit #(.MEM_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mem_stage_unit #(.MEM_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int lat, logic [2:0] m, logic [1:0] wb, logic [31:0] alu, logic [31:0] rd2, logic [4:0] rd);
    case (lat)
      1: begin b1.M = m; b1.WB = wb; b1.ALU = alu; b1.RD2 = rd2; b1.Mux5bit = rd; end
      2: begin b2.M = m; b2.WB = wb; b2.ALU = alu; b2.RD2 = rd2; b2.Mux5bit = rd; end
      default: begin b4.M = m; b4.WB = wb; b4.ALU = alu; b4.RD2 = rd2; b4.Mux5bit = rd; end
    endcase
  endtask
  task automatic get(int lat, output logic s, output logic [1:0] wo, output logic [31:0] ao,
                     output logic [31:0] dout, output logic [4:0] ro);
    case (lat)
      1: begin s = b1.stall; wo = b1.wbWB; ao = b1.wbALU; dout = b1.wbReadData; ro = b1.wbMux5bit; end
      2: begin s = b2.stall; wo = b2.wbWB; ao = b2.wbALU; dout = b2.wbReadData; ro = b2.wbMux5bit; end
      default: begin s = b4.stall; wo = b4.wbWB; ao = b4.wbALU; dout = b4.wbReadData; ro = b4.wbMux5bit; end
    endcase
  endtask
  // Drives one instruction, counts stall cycles (each must insert a bubble),
  // then checks the MEM/WB fields after the completion edge.
  task automatic access(string tag, int lat, int ns, logic [2:0] m, logic [1:0] wb, logic [31:0] alu,
                        logic [31:0] rd2, logic [4:0] rd, output logic [31:0] dout);
    logic s;
    logic [1:0] wo;
    logic [31:0] ao;
    logic [4:0] ro;
    int n = 0;
    drive(lat, m, wb, alu, rd2, rd);
    #1 get(lat, s, wo, ao, dout, ro);
    while (s === 1'b1 && n < 20) begin
      tick();
      get(lat, s, wo, ao, dout, ro);
      chk({tag, " bubble wbWB"}, 32'(wo), 32'd0);
      n++;
    end
    chk({tag, " stall cycles"}, n, ns);
    tick();
    get(lat, s, wo, ao, dout, ro);
    chk({tag, " wbWB"}, 32'(wo), 32'(wb));
    chk({tag, " wbALU"}, ao, alu);
    chk({tag, " wbMux5bit"}, 32'(ro), 32'(rd));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    b1.Adder = 0; b1.ZF = 0; b2.Adder = 0; b2.ZF = 0; b4.Adder = 0; b4.ZF = 0;
    drive(1, 3'b000, 2'b00, 0, 0, 0);
    drive(2, 3'b000, 2'b00, 0, 0, 0);
    drive(4, 3'b000, 2'b00, 0, 0, 0);
    tick();
    tick();
    get(4, st, w, a, d, r);
    chk("reset stall", 32'(st), 0);
    chk("reset wbWB", 32'(w), 0);
    chk("reset wbALU", a, 0);
    chk("reset wbReadData", d, 0);
    chk("reset wbMux5bit", 32'(r), 0);
    chk("reset PCSrc", 32'(b4.PCSrc), 0);
    rst_n = 1'b1;
    // reset in the middle of a LAT=4 store must discard it
    access("pre st", 4, 3, 3'b001, 2'b00, 32'h10, 32'h11112222, 5'd3, d);
    drive(4, 3'b001, 2'b00, 32'h10, 32'hDEADBEEF, 5'd3);
    tick();
    tick();
    rst_n = 1'b0;
    #1 get(4, st, w, a, d, r);
    chk("midrst stall", 32'(st), 0);
    chk("midrst wbWB", 32'(w), 0);
    chk("midrst wbALU", a, 0);
    chk("midrst wbMux5bit", 32'(r), 0);
    chk("midrst wbReadData", d, 0);
    drive(4, 3'b000, 2'b00, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    access("midrst ld", 4, 3, 3'b010, 2'b11, 32'h10, 0, 5'd9, d);
    chk("midrst old data", d, 32'h11112222);
    access("lat4 st", 4, 3, 3'b001, 2'b00, 32'h30, 32'hCAFEF00D, 5'd0, d);
    access("lat4 ld", 4, 3, 3'b010, 2'b11, 32'h30, 0, 5'd12, d);
    chk("lat4 data", d, 32'hCAFEF00D);
    drive(4, 3'b000, 2'b00, 0, 0, 0);
    access("lat2 st", 2, 1, 3'b001, 2'b00, 32'h20, 32'h12345678, 5'd0, d);
    access("lat2 ld", 2, 1, 3'b010, 2'b11, 32'h20, 0, 5'd5, d);
    chk("lat2 data", d, 32'h12345678);
    access("lat2 alu", 2, 0, 3'b000, 2'b10, 32'hABC, 0, 5'd7, d);
    chk("lat2 alu data hold", d, 32'h12345678);
    b2.M = 3'b100; b2.ZF = 1'b1; b2.Adder = 32'h40;
    #1;
    chk("br taken PCSrc", 32'(b2.PCSrc), 1);
    chk("br BranchAddr", b2.BranchAddr, 32'h40);
    chk("br stall", 32'(b2.stall), 0);
    b2.ZF = 1'b0;
    #1;
    chk("br not taken PCSrc", 32'(b2.PCSrc), 0);
    b2.M = 3'b000; b2.ZF = 1'b1;
    #1;
    chk("no branch PCSrc", 32'(b2.PCSrc), 0);
    b2.ZF = 1'b0;
    tick();
    access("wrap st", 2, 1, 3'b001, 2'b00, 32'h400, 32'h0BADC0DE, 5'd0, d);
    access("wrap ld", 2, 1, 3'b010, 2'b01, 32'h000, 0, 5'd2, d);
    chk("wrap data", d, 32'h0BADC0DE);
    drive(2, 3'b000, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      access("lat1 st", 1, 0, 3'b001, 2'b00, 32'h40 + 32'(i * 4), 32'hA5000000 + 32'(i * 'h111), 5'd0, d);
      access("lat1 ld", 1, 0, 3'b010, 2'b11, 32'h40 + 32'(i * 4), 0, 5'(i + 1), d);
      chk("lat1 data", d, 32'hA5000000 + 32'(i * 'h111));
    end
    access("rw st", 1, 0, 3'b011, 2'b01, 32'h80, 32'h77, 5'd4, d);
    chk("rw no read", d, 32'hA5000333);
    access("rw ld", 1, 0, 3'b010, 2'b11, 32'h80, 0, 5'd4, d);
    chk("rw data", d, 32'h77);
    drive(1, 3'b000, 2'b00, 0, 0, 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
